// File: rtl/arm_cpu_pkg.sv
// rtl/arm_cpu_pkg.sv - shared types and constants for the ARM fetch path
package arm_cpu_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Bytes per instruction word; the PC advances by this on each fetch
  localparam word_t INSTR_BYTES = 32'd4;
  // ARM reads of R15 return the instruction address plus this offset
  localparam word_t PC_READ_OFFSET = 32'd8;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC select: aligned branch target, hold, or sequential step
module pc_next_logic
  import arm_cpu_pkg::*;
(
  input  word_t pc,
  input  logic  branch_taken,
  input  word_t branch_target,
  input  logic  advance,
  output word_t pc_next
);

  // Branch wins over everything; its low two bits are forced to zero so the PC stays word aligned
  always_comb begin
    pc_next = pc;
    if (branch_taken) begin
      pc_next = branch_target & ~word_t'(32'h3);
    end else if (advance) begin
      pc_next = pc + INSTR_BYTES;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, range fault
module fetch_stage
  import arm_cpu_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus8,
  output logic        fetch_fault
);

  // One extra bit so a depth of 2^30 words still compares correctly
  localparam logic [30:0] DEPTH_WORDS = 31'(IMEM_DEPTH);

  word_t        pc;
  word_t        pc_next;
  fetch_state_t state;
  fetch_state_t state_next;
  logic         fault_next;
  logic         in_range;
  logic         fetch_go;

  assign imem_addr = {2'b00, pc[31:2]};
  assign in_range  = {1'b0, pc[31:2]} < DEPTH_WORDS;
  // An unstalled, unredirected edge in FETCH consumes the memory word or faults
  assign fetch_go  = (state == FETCH) && !stall && !branch_taken;

  pc_next_logic u_pc_next (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .advance       (fetch_go && in_range),
    .pc_next       (pc_next)
  );

  // State, fault flag and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_fault <= 1'b0;
      pc          <= RESET_PC;
    end else begin
      state       <= state_next;
      fetch_fault <= fault_next;
      pc          <= pc_next;
    end
  end

  // Next state: out-of-range fetch halts; only a branch resumes fetching
  always_comb begin
    state_next = state;
    fault_next = fetch_fault;
    if (branch_taken) begin
      state_next = FETCH;
      fault_next = 1'b0;
    end else if (fetch_go && !in_range) begin
      state_next = HALT;
      fault_next = 1'b1;
    end
  end

  // IF/ID pipeline register; a flush or fault only clears valid, the payload holds
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus8 <= '0;
    end else if (branch_taken || state == HALT) begin
      if_valid <= 1'b0;
    end else if (!stall) begin
      if (in_range) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_instr;
        if_pc       <= pc;
        if_pc_plus8 <= pc + PC_READ_OFFSET;
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule
